// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared state encodings and display constants for TM1638 feeders.
package tm1638_pkg;
  typedef enum logic [2:0] {
    ST_START,
    ST_IDLE,
    ST_LOAD,
    ST_PREP,
    ST_ISSUE,
    ST_DRAIN,
    ST_NEXT
  } state_t;
  localparam int FRAME_LEN = 16;
  localparam logic [3:0] LAST_ADDR = 4'(FRAME_LEN - 1);
  // Digits sit on even addresses, LEDs on the odd address that follows each digit.
  localparam logic DIGIT_BASE = 1'b0;
  // Indexed by nibble; bit0 = segment a .. bit6 = segment g.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/tm1638_hex_to_seg.sv
// tm1638_hex_to_seg: nibble plus decimal point to TM1638 segment byte.
module tm1638_hex_to_seg
  import tm1638_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg_byte
);
  assign seg_byte = {dp, SEG_LUT[nibble]};
endmodule

// File: rtl/tm1638_frame_writer.sv
// tm1638_frame_writer: snapshots hex/dots/LEDs and streams 16 single-address
// writes to a TM1638 driver, optionally skipping bytes that have not changed.
module tm1638_frame_writer
  import tm1638_pkg::*;
#(
  parameter logic SKIP_UNCHANGED = 1'b1
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic [31:0] HEX_VALUE,
  input  logic [7:0]  DOTS,
  input  logic [7:0]  LEDS,
  input  logic        UPDATE,
  input  logic        READY_IN,
  output logic [7:0]  DATA_OUT,
  output logic [3:0]  ADDR_OUT,
  output logic        WRITE_OUT,
  output logic        BUSY
);
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, addr_q, addr_d;
  logic [7:0]  data_q, data_d, dots_q, dots_d, leds_q, leds_d;
  logic [31:0] hex_q, hex_d;
  logic        pending_q, pending_d;
  logic [15:0] valid_q, valid_d;
  logic [7:0]  shadow_q [FRAME_LEN];
  logic [7:0]  shadow_d [FRAME_LEN];
  logic [2:0]  pos;
  logic [7:0]  digit_byte, byte_w;
  logic        skip;

  // Digit 0 is leftmost, so it maps to the most significant nibble/bit.
  assign pos = ~idx_q[3:1];

  tm1638_hex_to_seg u_enc (
    .nibble   (hex_q[{pos, 2'b00} +: 4]),
    .dp       (dots_q[pos]),
    .seg_byte (digit_byte)
  );

  assign byte_w    = (idx_q[0] == DIGIT_BASE) ? digit_byte : {7'b0, leds_q[pos]};
  assign skip      = SKIP_UNCHANGED && valid_q[idx_q] && (shadow_q[idx_q] == byte_w);
  assign DATA_OUT  = data_q;
  assign ADDR_OUT  = addr_q;
  assign WRITE_OUT = (state_q == ST_ISSUE);
  assign BUSY      = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    hex_d     = hex_q;
    dots_d    = dots_q;
    leds_d    = leds_q;
    valid_d   = valid_q;
    shadow_d  = shadow_q;
    pending_d = pending_q | (UPDATE && state_q != ST_IDLE && state_q != ST_LOAD);
    case (state_q)
      ST_START: state_d = READY_IN ? ST_LOAD : ST_START;
      ST_IDLE:  state_d = UPDATE ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        hex_d     = HEX_VALUE;
        dots_d    = DOTS;
        leds_d    = LEDS;
        idx_d     = '0;
        pending_d = 1'b0;
        state_d   = ST_PREP;
      end
      ST_PREP: begin
        if (skip) begin
          state_d = ST_NEXT;
        end else if (READY_IN) begin
          data_d  = byte_w;
          addr_d  = idx_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!READY_IN) begin
          shadow_d[idx_q] = data_q;
          valid_d[idx_q]  = 1'b1;
          state_d         = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = READY_IN ? ST_NEXT : ST_DRAIN;
      ST_NEXT: begin
        if (idx_q == LAST_ADDR) begin
          // An UPDATE landing on this very cycle must not be lost in IDLE.
          state_d = (pending_q || UPDATE) ? ST_LOAD : ST_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_PREP;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      state_q   <= ST_START;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      hex_q     <= '0;
      dots_q    <= '0;
      leds_q    <= '0;
      valid_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      hex_q     <= hex_d;
      dots_q    <= dots_d;
      leds_q    <= leds_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  // Shadow contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge CLK_IN) begin
    shadow_q <= shadow_d;
  end
endmodule

// File: tb/tb_tm1638_frame_writer.sv
// tb_tm1638_frame_writer: directed bench with a TM1638 driver handshake model.
module tb_tm1638_frame_writer;
  logic        clk, rst_n, update, ready, write, busy;
  logic [31:0] hex_value;
  logic [7:0]  dots, leds, data;
  logic [3:0]  addr;
  logic        ready2, write2, busy2;
  logic [7:0]  data2;
  logic [3:0]  addr2;
  logic        ready_en;
  int          hold_extra, busy_cyc, cnt2, viol, errors, checks;
  logic [11:0] wq[$];
  logic [11:0] exp_q[$];
  logic [11:0] exp5[$];

  tm1638_frame_writer #(.SKIP_UNCHANGED(1'b1)) dut (
    .CLK_IN(clk), .RST_IN(rst_n), .HEX_VALUE(hex_value), .DOTS(dots), .LEDS(leds),
    .UPDATE(update), .READY_IN(ready), .DATA_OUT(data), .ADDR_OUT(addr),
    .WRITE_OUT(write), .BUSY(busy)
  );

  tm1638_frame_writer #(.SKIP_UNCHANGED(1'b0)) dut2 (
    .CLK_IN(clk), .RST_IN(rst_n), .HEX_VALUE(hex_value), .DOTS(dots), .LEDS(leds),
    .UPDATE(update), .READY_IN(ready2), .DATA_OUT(data2), .ADDR_OUT(addr2),
    .WRITE_OUT(write2), .BUSY(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver model: latches a write after hold_extra cycles of READY high, then stays busy.
  initial begin
    logic [3:0] a;
    logic [7:0] d;
    ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!ready_en || !rst_n) ready = 1'b0;
      else if (!ready) ready = 1'b1;
      else if (write) begin
        a = addr;
        d = data;
        for (int k = 0; k < hold_extra && rst_n; k++) begin
          @(negedge clk);
          if (rst_n) chk("hold_stable", {write, addr, data}, {1'b1, a, d});
        end
        if (rst_n) begin
          wq.push_back({a, d});
          ready = 1'b0;
          @(negedge clk);
          if (rst_n) chk("wr_drop", write, 1'b0);
          repeat (busy_cyc) @(negedge clk);
        end
      end
    end
  end

  initial begin
    ready2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!ready_en || !rst_n) ready2 = 1'b0;
      else if (write2 && ready2) begin
        cnt2++;
        ready2 = 1'b0;
      end else ready2 = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (write && !ready) viol++;
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    while ((busy || busy2) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, busy || busy2, 1'b0);
  endtask

  task automatic wait_wr(input logic [3:0] a, input string tag);
    int n;
    n = 0;
    while (!(write && addr == a) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, write && addr == a, 1'b1);
  endtask

  task automatic pulse_update();
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk($sformatf("%s_count", tag), wq.size(), exp_q.size());
    foreach (exp_q[i]) if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
  endtask

  initial begin
    int n, k, bad;
    errors = 0; checks = 0; viol = 0; cnt2 = 0;
    rst_n = 1'b0; update = 1'b0; ready_en = 1'b0; hold_extra = 0; busy_cyc = 2;
    hex_value = 32'h0123ABCD; dots = 8'h00; leds = 8'h00;
    exp5 = '{12'h071, 12'h101, 12'h271, 12'h301, 12'h471, 12'h501, 12'h671, 12'h700,
             12'h871, 12'h901, 12'hA71, 12'hB00, 12'hC71, 12'hD00, 12'hEF1, 12'hF00};
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_addr", addr, 4'h0);
    chk("rst_write", write, 1'b0);
    chk("rst_busy", busy, 1'b1);
    rst_n = 1'b1;
    // Frame 1: automatic after driver init
    repeat (20) @(negedge clk);
    chk("t1_no_wr_before_ready", write, 1'b0);
    ready_en = 1'b1;
    wait_idle("t1_idle");
    exp_q = '{12'h03F, 12'h100, 12'h206, 12'h300, 12'h45B, 12'h500, 12'h64F, 12'h700,
              12'h877, 12'h900, 12'hA7C, 12'hB00, 12'hC39, 12'hD00, 12'hE5E, 12'hF00};
    check_writes("t1");
    chk("t1_busy", busy, 1'b0);
    chk("t1_dut2_count", cnt2, 16);
    // Only changed bytes rewritten; non-skipping instance rewrites all
    wq.delete(); cnt2 = 0;
    leds = 8'h80; dots = 8'h01;
    pulse_update();
    wait_idle("t2_idle");
    exp_q = '{12'h101, 12'hEDE};
    check_writes("t2");
    chk("t2_dut2_count", cnt2, 16);
    chk("t2_dut2_last", {addr2, data2}, {4'hF, 8'h00});
    // Long READY hold before latching
    wq.delete(); hold_extra = 5;
    leds = 8'hC0;
    pulse_update();
    wait_idle("t3_idle");
    exp_q = '{12'h301};
    check_writes("t3");
    // UPDATE bursts mid-frame collapse into one follow-up frame
    wq.delete(); hold_extra = 4;
    leds = 8'hE0;
    pulse_update();
    wait_wr(4'd5, "t4_wr5_seen");
    hex_value = 32'hFFFFFFFF;
    repeat (3) pulse_update();
    wait_idle("t4_idle");
    hold_extra = 0;
    repeat (20) @(negedge clk);
    chk("t4_busy_after", busy, 1'b0);
    exp_q = '{12'h501, 12'h071, 12'h271, 12'h471, 12'h671, 12'h871, 12'hA71, 12'hC71, 12'hEF1};
    check_writes("t4");
    // Async reset while issuing address 9
    wq.delete(); hold_extra = 10;
    leds = 8'hE8;
    pulse_update();
    wait_wr(4'd9, "t5_wr9_seen");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_write_async", write, 1'b0);
    chk("t5_busy_rst", busy, 1'b1);
    chk("t5_addr_rst", addr, 4'h0);
    ready_en = 1'b0; hold_extra = 0;
    repeat (3) @(negedge clk);
    wq.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ready_en = 1'b1;
    wait_idle("t5_idle");
    exp_q = exp5;
    check_writes("t5");
    // Driver stuck in init for 1000 cycles
    @(negedge clk);
    rst_n = 1'b0; ready_en = 1'b0;
    repeat (3) @(negedge clk);
    wq.delete();
    rst_n = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (write || !busy) bad++;
    end
    chk("t6_stall", bad, 0);
    ready_en = 1'b1;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    k = 1;
    while (!write && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t6_latency_le3", k <= 3, 1'b1);
    wait_idle("t6_idle");
    check_writes("t6");
    chk("no_wr_while_busy", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
